// File: rtl/iv_merge_wb_pkg.sv
// iv_merge_wb_pkg: shared FSM encoding, widths and IV field mask helper
package iv_merge_wb_pkg;
    localparam int DATA_W = 8;
    localparam int RADDR_W = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2} state_t;
    function automatic logic [DATA_W-1:0] field_mask(input logic [2:0] pos, input logic [2:0] len);
        logic [15:0] m;
        m = ((16'd1 << (len == 3'd0 ? 4'd8 : {1'b0, len})) - 16'd1) << pos;
        return m[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/iv_merge_wb_if.sv
// iv_merge_wb_if: IV bus read/write request-acknowledge handshake
interface iv_merge_wb_if;
    import iv_merge_wb_pkg::*;
    logic              iv_rd_req;
    logic              iv_rd_ack;
    logic [DATA_W-1:0] iv_rd_data;
    logic              iv_wr_req;
    logic              iv_wr_ack;
    logic [DATA_W-1:0] iv_wr_data;
    modport master (output iv_rd_req, iv_wr_req, iv_wr_data, input iv_rd_ack, iv_rd_data, iv_wr_ack);
    modport slave (input iv_rd_req, iv_wr_req, iv_wr_data, output iv_rd_ack, iv_rd_data, iv_wr_ack);
endinterface

// File: rtl/iv_merge_wb_field_merge.sv
// iv_field_merge: inserts a shifted value into a masked bit field of an old byte
module iv_field_merge
    import iv_merge_wb_pkg::*;
(
    input  logic [DATA_W-1:0] old,
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        pos,
    input  logic [2:0]        len,
    output logic [DATA_W-1:0] merged
);
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] sdata;
    // bits shifted past the top are dropped, never wrapped
    always_comb begin
        mask   = field_mask(pos, len);
        sdata  = data << pos;
        merged = (old & ~mask) | (sdata & mask);
    end
endmodule

// File: rtl/iv_merge_wb.sv
// iv_merge_wb: ALU writeback to register file or IV bus with field merge
module iv_merge_wb
    import iv_merge_wb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  alu_data,
    input  logic               dest_iv,
    input  logic [RADDR_W-1:0] reg_addr,
    input  logic [2:0]         field_pos,
    input  logic [2:0]         field_len,
    output logic               reg_we,
    output logic [RADDR_W-1:0] reg_waddr,
    output logic [DATA_W-1:0]  reg_wdata,
    output logic               busy,
    iv_merge_wb_if.master      iv
);
    state_t            state;
    logic [DATA_W-1:0] lat_data;
    logic [2:0]        lat_pos;
    logic [2:0]        lat_len;
    logic [DATA_W-1:0] merged;

    iv_field_merge u_merge (
        .old    (iv.iv_rd_data),
        .data   (lat_data),
        .pos    (lat_pos),
        .len    (lat_len),
        .merged (merged)
    );

    // writeback FSM; merge uses latched field geometry, never live inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            reg_we        <= 1'b0;
            reg_waddr     <= '0;
            reg_wdata     <= '0;
            busy          <= 1'b0;
            lat_data      <= '0;
            lat_pos       <= '0;
            lat_len       <= '0;
            iv.iv_rd_req  <= 1'b0;
            iv.iv_wr_req  <= 1'b0;
            iv.iv_wr_data <= '0;
        end else begin
            reg_we <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        lat_data <= alu_data;
                        lat_pos  <= field_pos;
                        lat_len  <= field_len;
                        if (!dest_iv) begin
                            reg_we    <= 1'b1;
                            reg_waddr <= reg_addr;
                            reg_wdata <= alu_data;
                        end else if (field_len == 3'd0 && field_pos == 3'd0) begin
                            iv.iv_wr_data <= alu_data;
                            iv.iv_wr_req  <= 1'b1;
                            in_ready      <= 1'b0;
                            busy          <= 1'b1;
                            state         <= WR_WAIT;
                        end else begin
                            iv.iv_rd_req <= 1'b1;
                            in_ready     <= 1'b0;
                            busy         <= 1'b1;
                            state        <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: if (iv.iv_rd_ack) begin
                    iv.iv_wr_data <= merged;
                    iv.iv_rd_req  <= 1'b0;
                    iv.iv_wr_req  <= 1'b1;
                    state         <= WR_WAIT;
                end
                WR_WAIT: if (iv.iv_wr_ack) begin
                    iv.iv_wr_req <= 1'b0;
                    busy         <= 1'b0;
                    in_ready     <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iv_merge_wb.sv
// tb_iv_merge_wb: directed scenario checks for the IV merge writeback stage
module tb_iv_merge_wb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] alu_data = 8'h00;
    logic       dest_iv = 1'b0;
    logic [2:0] reg_addr = 3'd0;
    logic [2:0] field_pos = 3'd0;
    logic [2:0] field_len = 3'd0;
    logic       reg_we;
    logic [2:0] reg_waddr;
    logic [7:0] reg_wdata;
    logic       busy;
    int         n_chk = 0;
    int         n_pass = 0;

    iv_merge_wb_if iv ();

    iv_merge_wb dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_data  (alu_data),
        .dest_iv   (dest_iv),
        .reg_addr  (reg_addr),
        .field_pos (field_pos),
        .field_len (field_len),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .busy      (busy),
        .iv        (iv)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0h want 0", in_ready); else n_pass++;
        n_chk++; if (reg_we !== 1'b0) $display("FAIL rst_reg_we: got %0h want 0", reg_we); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0h want 0", busy); else n_pass++;
        n_chk++; if (iv.iv_rd_req !== 1'b0 || iv.iv_wr_req !== 1'b0) $display("FAIL rst_reqs: got %0h%0h want 00", iv.iv_rd_req, iv.iv_wr_req); else n_pass++;
        n_chk++; if (iv.iv_wr_data !== 8'h00) $display("FAIL rst_wr_data: got %h want 00", iv.iv_wr_data); else n_pass++;
        rst = 1'b0;
        tick();
        n_chk++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %0h want 1", in_ready); else n_pass++;
    endtask

    task automatic test_reg_write(input string tag);
        in_valid = 1'b1; dest_iv = 1'b0; alu_data = 8'h5A; reg_addr = 3'd3;
        tick();
        in_valid = 1'b0;
        n_chk++; if (reg_we !== 1'b1) $display("FAIL %s_reg_we: got %0h want 1", tag, reg_we); else n_pass++;
        n_chk++; if (reg_waddr !== 3'd3 || reg_wdata !== 8'h5A) $display("FAIL %s_reg_addr_data: got %0d/%h want 3/5a", tag, reg_waddr, reg_wdata); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL %s_in_ready: got %0h want 1", tag, in_ready); else n_pass++;
        tick();
        n_chk++; if (reg_we !== 1'b0) $display("FAIL %s_reg_we_drop: got %0h want 0", tag, reg_we); else n_pass++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; dest_iv = 1'b0; alu_data = 8'h11; reg_addr = 3'd1;
        tick();
        n_chk++; if (reg_we !== 1'b1 || reg_waddr !== 3'd1 || reg_wdata !== 8'h11) $display("FAIL b2b_first: got %0h/%0d/%h want 1/1/11", reg_we, reg_waddr, reg_wdata); else n_pass++;
        alu_data = 8'h22; reg_addr = 3'd2;
        tick();
        in_valid = 1'b0;
        n_chk++; if (reg_we !== 1'b1 || reg_waddr !== 3'd2 || reg_wdata !== 8'h22) $display("FAIL b2b_second: got %0h/%0d/%h want 1/2/22", reg_we, reg_waddr, reg_wdata); else n_pass++;
        tick();
        n_chk++; if (reg_we !== 1'b0) $display("FAIL b2b_drop: got %0h want 0", reg_we); else n_pass++;
    endtask

    task automatic test_partial();
        in_valid = 1'b1; dest_iv = 1'b1; alu_data = 8'h05; field_pos = 3'd2; field_len = 3'd3;
        tick();
        in_valid = 1'b0; field_pos = 3'd7; field_len = 3'd1; alu_data = 8'h00;
        iv.iv_rd_data = 8'hFF;
        n_chk++; if (iv.iv_rd_req !== 1'b1 || iv.iv_wr_req !== 1'b0) $display("FAIL part_rd_req: got %0h%0h want 10", iv.iv_rd_req, iv.iv_wr_req); else n_pass++;
        n_chk++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL part_ready_busy: got %0h%0h want 01", in_ready, busy); else n_pass++;
        iv.iv_wr_ack = 1'b1;
        tick();
        iv.iv_wr_ack = 1'b0;
        n_chk++; if (iv.iv_rd_req !== 1'b1 || iv.iv_wr_req !== 1'b0) $display("FAIL part_stray_wr_ack: got %0h%0h want 10", iv.iv_rd_req, iv.iv_wr_req); else n_pass++;
        iv.iv_rd_ack = 1'b1;
        tick();
        iv.iv_rd_ack = 1'b0;
        iv.iv_rd_data = 8'h00;
        n_chk++; if (iv.iv_rd_req !== 1'b0 || iv.iv_wr_req !== 1'b1) $display("FAIL part_wr_req: got %0h%0h want 01", iv.iv_rd_req, iv.iv_wr_req); else n_pass++;
        n_chk++; if (iv.iv_wr_data !== 8'hF7) $display("FAIL part_wr_data: got %h want f7", iv.iv_wr_data); else n_pass++;
        tick();
        n_chk++; if (iv.iv_wr_data !== 8'hF7 || in_ready !== 1'b0) $display("FAIL part_hold: got %h/%0h want f7/0", iv.iv_wr_data, in_ready); else n_pass++;
        iv.iv_wr_ack = 1'b1;
        tick();
        iv.iv_wr_ack = 1'b0;
        n_chk++; if (iv.iv_wr_req !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL part_done: got %0h%0h%0h want 010", iv.iv_wr_req, in_ready, busy); else n_pass++;
    endtask

    task automatic test_full();
        in_valid = 1'b1; dest_iv = 1'b1; alu_data = 8'hA5; field_pos = 3'd0; field_len = 3'd0;
        tick();
        in_valid = 1'b0;
        n_chk++; if (iv.iv_rd_req !== 1'b0 || iv.iv_wr_req !== 1'b1) $display("FAIL full_reqs: got %0h%0h want 01", iv.iv_rd_req, iv.iv_wr_req); else n_pass++;
        n_chk++; if (iv.iv_wr_data !== 8'hA5 || busy !== 1'b1) $display("FAIL full_data: got %h/%0h want a5/1", iv.iv_wr_data, busy); else n_pass++;
        iv.iv_wr_ack = 1'b1;
        tick();
        iv.iv_wr_ack = 1'b0;
        n_chk++; if (iv.iv_rd_req !== 1'b0 || iv.iv_wr_req !== 1'b0 || in_ready !== 1'b1) $display("FAIL full_done: got %0h%0h%0h want 001", iv.iv_rd_req, iv.iv_wr_req, in_ready); else n_pass++;
    endtask

    task automatic test_truncation();
        in_valid = 1'b1; dest_iv = 1'b1; alu_data = 8'h0F; field_pos = 3'd6; field_len = 3'd4;
        iv.iv_rd_data = 8'h00;
        tick();
        in_valid = 1'b0;
        iv.iv_rd_ack = 1'b1;
        tick();
        iv.iv_rd_ack = 1'b0;
        n_chk++; if (iv.iv_wr_data !== 8'hC0 || iv.iv_wr_req !== 1'b1) $display("FAIL trunc_data: got %h/%0h want c0/1", iv.iv_wr_data, iv.iv_wr_req); else n_pass++;
        iv.iv_wr_ack = 1'b1;
        tick();
        iv.iv_wr_ack = 1'b0;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL trunc_done: got %0h want 1", in_ready); else n_pass++;
    endtask

    task automatic test_abort();
        in_valid = 1'b1; dest_iv = 1'b1; alu_data = 8'h33; field_pos = 3'd1; field_len = 3'd2;
        tick();
        in_valid = 1'b0;
        n_chk++; if (iv.iv_rd_req !== 1'b1) $display("FAIL abort_rd_req: got %0h want 1", iv.iv_rd_req); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if (iv.iv_rd_req !== 1'b0 || busy !== 1'b0 || iv.iv_wr_req !== 1'b0) $display("FAIL abort_drop: got %0h%0h%0h want 000", iv.iv_rd_req, busy, iv.iv_wr_req); else n_pass++;
        iv.iv_rd_ack = 1'b1;
        tick();
        iv.iv_rd_ack = 1'b0;
        n_chk++; if (iv.iv_wr_req !== 1'b0 || in_ready !== 1'b1) $display("FAIL abort_stray_ack: got %0h%0h want 01", iv.iv_wr_req, in_ready); else n_pass++;
        test_reg_write("abort_reg");
    endtask

    initial begin
        iv.iv_rd_ack = 1'b0;
        iv.iv_wr_ack = 1'b0;
        iv.iv_rd_data = 8'h00;
        test_reset();
        test_reg_write("reg");
        test_back_to_back();
        test_partial();
        test_full();
        test_truncation();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/iv_merge_wb.md
Name: iv_merge_wb

Overview:
Writeback stage directly downstream of the 8-bit ALU. It consumes the registered ALU result and routes it to one of two destinations:
- the internal register file, as a single-cycle write;
- the IV (interface vector) bus, as a masked field merge. Partial fields use a read-modify-write sequence; full-byte writes go straight to the bus.

The stage provides valid/ready backpressure to the sequencer and holds off new results while a bus transaction is outstanding.

Parameters:
- DATA_W, 8, datapath width; only 8 is supported.
- RADDR_W, 3, register-file address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  ALU result valid this cycle
- in_ready  out  1  stage can accept a result
- alu_data  in  8  ALU result (alu_out)
- dest_iv  in  1  0 = register destination, 1 = IV bus destination
- reg_addr  in  RADDR_W  destination register index
- field_pos  in  3  LSB position of the IV field
- field_len  in  3  IV field length; 0 encodes 8
- reg_we  out  1  register-file write strobe
- reg_waddr  out  RADDR_W  register write address
- reg_wdata  out  8  register write data
- iv_rd_req  out  1  IV read request
- iv_rd_ack  in  1  IV read acknowledge
- iv_rd_data  in  8  IV read data, valid when iv_rd_ack=1
- iv_wr_req  out  1  IV write request
- iv_wr_ack  in  1  IV write acknowledge
- iv_wr_data  out  8  IV write data
- busy  out  1  IV transaction in progress

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- On rst, every output is 0 and the FSM goes to IDLE. Exception: in_ready goes to 1 in the first cycle after rst deasserts.
- A result is accepted on a clk edge where in_valid && in_ready. All inputs are latched at that edge.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- in_ready = 1 only in IDLE. busy = 1 in RD_WAIT or WR_WAIT.
- Register destination (dest_iv=0):
  - In the cycle after acceptance: reg_we=1, reg_waddr and reg_wdata hold the latched values.
  - reg_we lasts exactly 1 cycle unless another register write was accepted at the same edge.
  - The FSM stays in IDLE, so back-to-back accepts give 1 write per cycle.
- Mask and merge:
  - mask = ((2^L - 1) << field_pos) truncated to 8 bits, where L = field_len, or 8 when field_len=0.
  - sdata = (alu_data << field_pos) truncated to 8 bits.
  - Bits shifted past bit 7 are discarded; there is no wrap.
- Full write: field_len=0 and field_pos=0. From IDLE, go to WR_WAIT with iv_wr_data = alu_data. No read is issued.
- Partial write: any other IV destination. From IDLE, go to RD_WAIT.
- RD_WAIT:
  - iv_rd_req=1, starting the cycle after acceptance.
  - On the edge where iv_rd_ack=1 is sampled:
    - iv_wr_data <= (iv_rd_data & ~mask) | (sdata & mask);
    - iv_rd_req drops and iv_wr_req rises in the next cycle (WR_WAIT).
- WR_WAIT:
  - iv_wr_req=1 and iv_wr_data held stable.
  - On the edge where iv_wr_ack=1 is sampled, go to IDLE. iv_wr_req=0 and in_ready=1 in the next cycle.
- iv_rd_req and iv_wr_req are never both 1 in the same cycle. Each request is held until its ack, with no timeout.
- An ack received in a state that does not expect it is ignored.
- Merge-time rule: mask and sdata are derived from the latched field_pos and field_len, never from the live inputs.
- rst during RD_WAIT or WR_WAIT aborts the transaction. Requests drop the next cycle and no partial write completes.
- OVF and NZ flags are not handled by this stage.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, RD_WAIT=2'd1, WR_WAIT=2'd2);
  - the constants DATA_W and RADDR_W;
  - the function field_mask(pos, len) implementing the length-0 = 8 rule.
- One combinational sub-module, iv_field_merge (inputs old, data, pos, len; output merged), is natural. It is reused by a future IV read/extract stage.

Test Plan:
- Register write: accept alu_data=0x5A, dest_iv=0, reg_addr=3 → next cycle reg_we=1, reg_waddr=3, reg_wdata=0x5A. in_ready stays 1.
- Back-to-back register writes: 0x11→r1 then 0x22→r2 on consecutive cycles → reg_we=1 for 2 consecutive cycles with the matching address/data pairs.
- Partial merge: pos=2, len=3, alu_data=0x05, iv_rd_data=0xFF, ack after 2 cycles → iv_wr_data=0xF7. in_ready=0 until the cycle after iv_wr_ack.
- Full write: pos=0, len=0, alu_data=0xA5 → iv_rd_req never asserts; iv_wr_req=1 with iv_wr_data=0xA5 the cycle after acceptance.
- Truncation: pos=6, len=4, alu_data=0x0F, iv_rd_data=0x00 → mask=0xC0, iv_wr_data=0xC0.
- Abort: rst=1 while in RD_WAIT → next cycle iv_rd_req=0, busy=0, iv_wr_req never rises. The first post-reset register write behaves as in the first scenario.
